prng_rn_gen: RTL and testbench
==============================

# prng_rn_gen

Parametrised pseudo-random number generator for the Gen2 tag baseband. It produces RN16 handles and slot-counter values on request.
- A free-running Galois LFSR of configurable width and polynomial advances on every `clk_prng` edge.
- A request/valid FSM captures one number after a full register turnover, so consecutive outputs are decorrelated.
- Supports seed reload and zero-state lock-up recovery.
- Sits between the command decoder (Query/QueryRep/ReqRN) and the slot counter / backscatter encoder.

## Interface
Parameters:
- `WIDTH`, 16: LFSR and output width (4..32).
- `POLY`, 16'h0038: Galois tap mask. Bit i set (i ≥ 1) means `next[i] = cur[i-1] ^ cur[WIDTH-1]`. Bit 0 always takes `cur[WIDTH-1]`. The default gives 1 + x^3 + x^4 + x^5 + x^16.
- `SEED`, 16'h2A6C: reset value and zero-seed substitute. Must be non-zero.
- `STEPS`, `WIDTH`: LFSR shifts between request acceptance and capture (≥ 1).

Ports:
- `clk_prng`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `seed_ld`, in, 1: synchronous seed load strobe.
- `seed_in`, in, `WIDTH`: seed value.
- `req`, in, 1: request a new number (level, sampled only in IDLE).
- `q`, in, 4: Gen2 Q value for the slot mask.
- `prn`, out, `WIDTH`: current LFSR state.
- `busy`, out, 1: FSM not in IDLE.
- `rn_valid`, out, 1: one-cycle pulse, `rn`/`slot` updated.
- `rn`, out, `WIDTH`: captured random number, held until the next capture.
- `slot`, out, `WIDTH`: captured value masked to the low `q` bits.

## Operation
LFSR update priority, per edge:
1. `seed_ld` loads `seed_in`, or `SEED` if `seed_in == 0`.
2. Otherwise, if `prn == 0` (corruption guard), load `SEED`.
3. Otherwise, Galois shift per `POLY`.

FSM states: IDLE, GEN, DONE.
- IDLE → GEN when `req == 1` and `seed_ld == 0`. `cnt` is cleared to 0.
- GEN: `cnt` increments each edge.
  - On the edge where `cnt == STEPS-1`, capture `rn <= prn` (pre-shift value) and `slot <= prn & mask(q)`, with `q` sampled at that edge. Then go to DONE.
- DONE → IDLE unconditionally. `rn_valid = (state == DONE)`, registered.
- `seed_ld` in GEN aborts to IDLE: no capture, no `rn_valid`. `seed_ld` in DONE is a normal load; DONE still completes.
- `req` is ignored in GEN and DONE. A held `req` restarts GEN from IDLE, giving one number every `STEPS+2` cycles.

Slot mask:
- `mask(q) = (1 << q) - 1`.
- `q = 0` → `slot = 0`.
- `q ≥ WIDTH` → mask is all ones.

Reset values: `prn = SEED`, `rn = 0`, `slot = 0`, `rn_valid = 0`, `busy = 0`, state IDLE, `cnt = 0`.

Reset asserted mid-GEN returns every register to its reset value immediately. No `rn_valid` is produced.

## Timing
- `req` sampled at edge k (IDLE) → `busy = 1` after edge k.
- Capture happens at edge k+`STEPS`. `rn_valid` is high for the single cycle after edge k+`STEPS`.
- `busy` deasserts after edge k+`STEPS`+1.
- `prn` changes every cycle. The `seed_ld` value is visible on `prn` one cycle after the load edge.
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `PRNG_SLOT_EN` defined: `q` input and `slot` register are implemented as described.
- `PRNG_SLOT_EN` undefined: `slot` is tied to 0 and `q` is unused. `rn`, `rn_valid` and FSM behaviour are unchanged.

## Structure
- Package `prng_pkg` holds:
  - `PRNG_POLY16` (16'h0038) and `PRNG_SEED16` (16'h2A6C) constants.
  - FSM state enum `prng_state_t` {IDLE, GEN, DONE}.
  - Function `slot_mask(q, width)`.
- Sub-module `lfsr_galois` (parameters `WIDTH`, `POLY`, `SEED`) contains the LFSR register with load, the zero-state guard and the async reset.
- `prng_rn_gen` contains the FSM, counter and capture registers.

## Test plan
- Free-run with default parameters: release reset, no inputs → `prn` = 2A6C, 54D8, A9B0, 5359 on successive cycles.
- Request: `req` one cycle at edge k → `rn_valid` single pulse after edge k+16, and `rn` equals `prn` sampled in the cycle before that pulse. With `q = 4`, `slot = rn & 16'h000F`.
- Seed load: `seed_ld = 1`, `seed_in = 0` → `prn = 2A6C` next cycle. `seed_in = 16'h1234` → `prn = 1234` next cycle.
- Abort: `seed_ld` pulse at `cnt = 5` in GEN → no `rn_valid`, `busy` low next cycle, `rn` unchanged.
- Boundaries: `q = 0` → `slot = 0`. `q = 15` → `slot = rn & 7FFF`. Held `req` → `rn_valid` pulses exactly 18 cycles apart.
- Reset mid-GEN: assert `rst_n` low at `cnt = 8` → all outputs at reset values immediately. After release, the `prn` sequence restarts from 2A6C.

Source files
------------

// File: rtl/prng_pkg.sv
// ---------------------------------------------------------------------------
// prng_pkg
// Shared definitions for the Gen2 pseudo-random number generator.
//   PRNG_POLY16  : default 16-bit Galois tap mask (1 + x^3 + x^4 + x^5 + x^16)
//   PRNG_SEED16  : default non-zero reset / substitute seed
//   prng_state_t : request FSM states
//   slot_mask()  : low-q-bits mask used for the slot counter value
// ---------------------------------------------------------------------------
package prng_pkg;

    localparam logic [15:0] PRNG_POLY16 = 16'h0038;
    localparam logic [15:0] PRNG_SEED16 = 16'h2A6C;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } prng_state_t;

    // (1 << q) - 1, saturating to all ones once q reaches the output width.
    function automatic logic [31:0] slot_mask(input logic [3:0] q, input int unsigned width);
        logic [31:0] m;
        if (int'(q) >= int'(width)) begin
            m = '1;
        end else begin
            m = (32'd1 << q) - 32'd1;
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// ---------------------------------------------------------------------------
// lfsr_galois
// Free-running Galois LFSR with synchronous load and zero-state recovery.
// Per edge: load (zero load value replaced by SEED) > zero-state guard > shift.
// Ports:
//   clk_prng   in   clock
//   rst_n      in   asynchronous active-low reset (state <= SEED)
//   load       in   synchronous load strobe
//   load_value in   value to load (0 means "use SEED")
//   state      out  current LFSR register
// ---------------------------------------------------------------------------
module lfsr_galois
    import prng_pkg::*;
#(
    parameter int unsigned          WIDTH = 16,
    parameter logic [WIDTH-1:0]     POLY  = WIDTH'(PRNG_POLY16),
    parameter logic [WIDTH-1:0]     SEED  = WIDTH'(PRNG_SEED16)
) (
    input  logic             clk_prng,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state
);

    // Bit 0 always receives the feedback bit directly, so POLY[0] is ignored.
    localparam logic [WIDTH-1:0] TAPS = POLY & ~WIDTH'(1);

    logic [WIDTH-1:0] shifted;

    always_comb begin
        shifted = {state[WIDTH-2:0], state[WIDTH-1]};
        if (state[WIDTH-1]) begin
            shifted = shifted ^ TAPS;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk_prng or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (load) begin
            state <= (load_value == '0) ? SEED : load_value;
        end else if (state == '0) begin
            state <= SEED;
        end else begin
            state <= shifted;
        end
    end

endmodule

// File: rtl/prng_rn_gen.sv
// ---------------------------------------------------------------------------
// prng_rn_gen
// RN16 / slot-value generator for the Gen2 tag baseband. A request accepted
// in IDLE lets the LFSR run STEPS further shifts before one value is captured,
// so consecutive outputs are separated by a full register turnover.
// Optional feature macro: PRNG_SLOT_EN (q input and slot register). When it is
// undefined, slot is tied to 0 and q is ignored.
// Ports:
//   clk_prng  in   clock
//   rst_n     in   asynchronous active-low reset
//   seed_ld   in   synchronous seed load (aborts a generation in progress)
//   seed_in   in   seed value (0 selects SEED)
//   req       in   request level, sampled only in IDLE
//   q         in   Gen2 Q value for the slot mask
//   prn       out  current LFSR state
//   busy      out  FSM not in IDLE
//   rn_valid  out  one-cycle pulse when rn/slot are updated
//   rn        out  captured random number
//   slot      out  captured number masked to the low q bits
// ---------------------------------------------------------------------------
module prng_rn_gen
    import prng_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(PRNG_POLY16),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(PRNG_SEED16),
    parameter int unsigned      STEPS = WIDTH
) (
    input  logic             clk_prng,
    input  logic             rst_n,
    input  logic             seed_ld,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             req,
    input  logic [3:0]       q,
    output logic [WIDTH-1:0] prn,
    output logic             busy,
    output logic             rn_valid,
    output logic [WIDTH-1:0] rn,
    output logic [WIDTH-1:0] slot
);

    localparam int unsigned      CNT_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

    prng_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             capture;

    lfsr_galois #(
        .WIDTH (WIDTH),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_lfsr (
        .clk_prng   (clk_prng),
        .rst_n      (rst_n),
        .load       (seed_ld),
        .load_value (seed_in),
        .state      (prn)
    );

    // A seed load during GEN wins over the capture on the same edge.
    assign capture = (state_q == GEN) && !seed_ld && (cnt_q == CNT_LAST);

    // NOTE: the async reset branch covers every flop here, including the
    // captured data, so a mid-generation reset leaves no stale number behind.
    always_ff @(posedge clk_prng or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it
    // unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (req && !seed_ld) state_d = GEN;
            GEN: begin
                if (seed_ld)      state_d = IDLE;
                else if (capture) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode the state register only, so they are glitch-free and
    // have no combinational path from any input.
    always_comb begin
        busy     = (state_q != IDLE);
        rn_valid = (state_q == DONE);
    end

    // cnt is 0 on entry to GEN and counts edges spent there.
    always_ff @(posedge clk_prng or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == GEN) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else begin
            cnt_q <= '0;
        end
    end

    always_ff @(posedge clk_prng or negedge rst_n) begin
        if (!rst_n) begin
            rn <= '0;
        end else if (capture) begin
            rn <= prn;
        end
    end

`ifdef PRNG_SLOT_EN
    always_ff @(posedge clk_prng or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (capture) begin
            slot <= prn & WIDTH'(slot_mask(q, WIDTH));
        end
    end
`else
    logic unused_q;
    assign unused_q = ^q;
    assign slot     = '0;
`endif

endmodule

// File: tb/tb_prng_rn_gen.sv
// ---------------------------------------------------------------------------
// tb_prng_rn_gen
// Directed self-checking bench for prng_rn_gen with default parameters
// (WIDTH 16, POLY 0038, SEED 2A6C, STEPS 16). Inputs change 1 ns after the
// rising edge; outputs are compared at that same point, clear of the edge.
// ---------------------------------------------------------------------------
module tb_prng_rn_gen;

    localparam logic [15:0] SEED  = 16'h2A6C;
    localparam logic [15:0] TAPS  = 16'h0038;
    localparam int          STEPS = 16;

    logic        clk_prng = 1'b0;
    logic        rst_n    = 1'b0;
    logic        seed_ld  = 1'b0;
    logic [15:0] seed_in  = '0;
    logic        req      = 1'b0;
    logic [3:0]  q        = '0;
    logic [15:0] prn, rn, slot;
    logic        busy, rn_valid;

    int          n_vec = 0;
    int          n_err = 0;

    logic [15:0] m_prn     = SEED;  // model of the LFSR after the last edge
    logic [15:0] m_prn_pre = SEED;  // model value just before the last edge
    logic [15:0] last_rn   = '0;    // last number the bench expects captured

    prng_rn_gen dut (
        .clk_prng (clk_prng),
        .rst_n    (rst_n),
        .seed_ld  (seed_ld),
        .seed_in  (seed_in),
        .req      (req),
        .q        (q),
        .prn      (prn),
        .busy     (busy),
        .rn_valid (rn_valid),
        .rn       (rn),
        .slot     (slot)
    );

    always #5 clk_prng = ~clk_prng;

    function automatic logic [15:0] model_next(input logic [15:0] cur, input logic ld,
                                               input logic [15:0] din);
        logic [15:0] nxt;
        if (ld)              nxt = (din == 16'h0) ? SEED : din;
        else if (cur == '0)  nxt = SEED;
        else begin
            nxt = {cur[14:0], cur[15]};
            if (cur[15]) nxt = nxt ^ TAPS;
        end
        return nxt;
    endfunction

    task automatic tick();
        @(posedge clk_prng);
        m_prn_pre = m_prn;
        m_prn     = rst_n ? model_next(m_prn, seed_ld, seed_in) : SEED;
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] seq [4];
        seq[0] = 16'h2A6C; seq[1] = 16'h54D8; seq[2] = 16'hA9B0; seq[3] = 16'h5359;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_prng);
        #1;
        n_vec++; if (prn !== SEED)   begin n_err++; $display("FAIL reset_prn got %h want %h", prn, SEED); end
        n_vec++; if (rn !== 16'h0)   begin n_err++; $display("FAIL reset_rn got %h want 0000", rn); end
        n_vec++; if (slot !== 16'h0) begin n_err++; $display("FAIL reset_slot got %h want 0000", slot); end
        n_vec++; if (rn_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL reset_flags got valid=%b busy=%b want 0 0", rn_valid, busy);
        end
        #2 rst_n = 1'b1;
        m_prn = SEED;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (prn !== seq[i]) begin
                n_err++; $display("FAIL freerun[%0d] got %h want %h", i, prn, seq[i]);
            end
            if (i < 3) tick();
        end
    endtask

    // One request pulse; checks latency, pulse width, rn and slot.
    task automatic do_request(input logic [3:0] qv, input logic [15:0] mask, input string tag);
        logic [15:0] exp_rn, exp_slot;
        int          early;
        q   = qv;
        req = 1'b1;
        tick();                         // edge k
        req = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL %s busy_start got %b want 1", tag, busy); end
        early = 0;
        for (int i = 1; i < STEPS; i++) begin
            tick();
            if (rn_valid !== 1'b0) early++;
        end
        n_vec++; if (early != 0) begin n_err++; $display("FAIL %s early_valid got %0d pulses want 0", tag, early); end
        exp_rn = m_prn;
        tick();                         // edge k+STEPS
        last_rn = exp_rn;
`ifdef PRNG_SLOT_EN
        exp_slot = exp_rn & mask;
`else
        exp_slot = 16'h0;
`endif
        n_vec++; if (rn_valid !== 1'b1) begin n_err++; $display("FAIL %s valid got %b want 1", tag, rn_valid); end
        n_vec++; if (rn !== exp_rn)     begin n_err++; $display("FAIL %s rn got %h want %h", tag, rn, exp_rn); end
        n_vec++; if (slot !== exp_slot) begin n_err++; $display("FAIL %s slot got %h want %h", tag, slot, exp_slot); end
        tick();                         // edge k+STEPS+1
        n_vec++; if (rn_valid !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL %s end got valid=%b busy=%b want 0 0", tag, rn_valid, busy);
        end
    endtask

    task automatic test_request();
        tick();
        do_request(4'd4, 16'h000F, "req_q4");
        tick();
        do_request(4'd4, 16'h000F, "req_q4_again");
    endtask

    task automatic test_slot_bounds();
        tick();
        do_request(4'd0,  16'h0000, "slot_q0");
        do_request(4'd15, 16'h7FFF, "slot_q15");
    endtask

    task automatic test_seed_load();
        seed_in = 16'h0000; seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
        n_vec++; if (prn !== 16'h2A6C) begin n_err++; $display("FAIL seed_zero got %h want 2a6c", prn); end
        tick(); tick();
        seed_in = 16'h1234; seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
        n_vec++; if (prn !== 16'h1234) begin n_err++; $display("FAIL seed_1234 got %h want 1234", prn); end
        tick();
        n_vec++; if (prn !== 16'h2468) begin n_err++; $display("FAIL seed_shift got %h want 2468", prn); end
    endtask

    task automatic test_abort();
        int pulses;
        req = 1'b1;
        tick();                          // edge k, cnt = 0
        req = 1'b0;
        repeat (5) tick();               // cnt = 5
        seed_in = 16'hBEEF; seed_ld = 1'b1;
        tick();
        seed_ld = 1'b0;
        n_vec++; if (busy !== 1'b0 || rn_valid !== 1'b0) begin
            n_err++; $display("FAIL abort_flags got busy=%b valid=%b want 0 0", busy, rn_valid);
        end
        n_vec++; if (rn !== last_rn) begin n_err++; $display("FAIL abort_rn got %h want %h", rn, last_rn); end
        n_vec++; if (prn !== 16'hBEEF) begin n_err++; $display("FAIL abort_prn got %h want beef", prn); end
        pulses = 0;
        repeat (24) begin
            tick();
            if (rn_valid === 1'b1) pulses++;
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL abort_late_valid got %0d pulses want 0", pulses); end
    endtask

    task automatic test_back_to_back();
        int t_last, seen, cyc;
        q = 4'd4;
        req = 1'b1;
        t_last = 0; seen = 0; cyc = 0;
        while (seen < 3 && cyc < 100) begin
            tick();
            cyc++;
            if (rn_valid === 1'b1) begin
                n_vec++; if (rn !== m_prn_pre) begin
                    n_err++; $display("FAIL b2b_rn[%0d] got %h want %h", seen, rn, m_prn_pre);
                end
                last_rn = m_prn_pre;
                if (seen > 0) begin
                    n_vec++; if (cyc - t_last != STEPS + 2) begin
                        n_err++; $display("FAIL b2b_gap[%0d] got %0d want %0d", seen, cyc - t_last, STEPS + 2);
                    end
                end
                t_last = cyc;
                seen++;
            end
        end
        req = 1'b0;
        n_vec++; if (seen != 3) begin n_err++; $display("FAIL b2b_timeout got %0d pulses want 3", seen); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_idle busy got %b want 0", busy); end
    endtask

    task automatic test_reset_mid_gen();
        int pulses;
        req = 1'b1;
        tick();                          // edge k, cnt = 0
        req = 1'b0;
        repeat (8) tick();               // cnt = 8
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (prn !== SEED || rn !== 16'h0 || slot !== 16'h0 || busy !== 1'b0 || rn_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midgen_reset got prn=%h rn=%h slot=%h busy=%b valid=%b want 2a6c 0000 0000 0 0",
                     prn, rn, slot, busy, rn_valid);
        end
        tick();
        #1 rst_n = 1'b1;
        m_prn = SEED;
        n_vec++; if (prn !== 16'h2A6C) begin n_err++; $display("FAIL midgen_seq0 got %h want 2a6c", prn); end
        tick();
        n_vec++; if (prn !== 16'h54D8) begin n_err++; $display("FAIL midgen_seq1 got %h want 54d8", prn); end
        tick();
        n_vec++; if (prn !== 16'hA9B0) begin n_err++; $display("FAIL midgen_seq2 got %h want a9b0", prn); end
        pulses = 0;
        repeat (20) begin
            tick();
            if (rn_valid === 1'b1 || busy === 1'b1) pulses++;
        end
        n_vec++; if (pulses != 0) begin n_err++; $display("FAIL midgen_quiet got %0d active cycles want 0", pulses); end
        n_vec++; if (prn !== m_prn) begin n_err++; $display("FAIL midgen_track got %h want %h", prn, m_prn); end
    endtask

    initial begin
        test_reset();
        test_request();
        test_slot_bounds();
        test_seed_load();
        test_abort();
        test_back_to_back();
        test_reset_mid_gen();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
